mem_sram_ctrl: RTL and testbench
================================

MEM_SRAM_CTRL -- requirements
Module: mem_sram_ctrl

Interface
REQ-001 Parameter: WAIT_CYCLES, default 1, SRAM wait states added per 16-bit half access (legal 0..7).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 MEM_R_EN  input  1  load request from the EXE/MEM pipeline register.
REQ-005 MEM_W_EN  input  1  store request from the EXE/MEM pipeline register.
REQ-006 ALU_result  input  32  byte address of the access.
REQ-007 ST_val  input  32  store data.
REQ-008 ready  output  1  high when no access is pending; the pipeline drives freeze = ~ready.
REQ-009 read_data  output  32  load result, valid while ready is high after a load.
REQ-010 SRAM_ADDR  output  18  SRAM half-word address.
REQ-011 SRAM_DQ_out, SRAM_DQ_in, SRAM_DQ_oe  output/input/output  16/16/1  split SRAM data bus and drive enable.
REQ-012 SRAM_WE_N  output  1  active-low SRAM write strobe.

Function
REQ-013 The block SHALL implement the FSM states IDLE, LOW, HIGH and DONE.
REQ-014 IDLE with (MEM_R_EN|MEM_W_EN)=1 SHALL drive ready=0 combinationally in that same cycle and move to LOW.
REQ-015 IDLE with no request SHALL hold ready=1.
REQ-016 LOW and HIGH SHALL each last WAIT_CYCLES+1 cycles, timed by a 3-bit counter cleared on every state entry.
REQ-017 LOW and HIGH SHALL drive ready=0.
REQ-018 DONE SHALL last exactly 1 cycle with ready=1 and then move to IDLE.
REQ-019 At the DONE edge the pipeline register advances, so IDLE SHALL evaluate the next instruction only.
REQ-020 Address mapping: word = (ALU_result - 32'd1024) >> 2, computed modulo 2^32.
REQ-021 Address mapping: SRAM_ADDR = {word[16:0], half}, with half=0 in LOW and half=1 in HIGH.
REQ-022 Store: SRAM_DQ_oe=1 throughout LOW/HIGH.
REQ-023 Store: SRAM_DQ_out = ST_val[15:0] in LOW and ST_val[31:16] in HIGH.
REQ-024 Store: SRAM_WE_N=0 in every cycle of a half except its last cycle, and 1 otherwise.
REQ-025 Load: SRAM_DQ_oe=0 and SRAM_WE_N=1.
REQ-026 Load: read_data[15:0] SHALL capture SRAM_DQ_in on the last cycle of LOW.
REQ-027 Load: read_data[31:16] SHALL capture SRAM_DQ_in on the last cycle of HIGH.
REQ-028 read_data SHALL hold its value until the next load capture.
REQ-029 MEM_R_EN and MEM_W_EN both high SHALL be treated as a store, leaving read_data unchanged.
REQ-030 ALU_result, ST_val and the request type SHALL be latched on IDLE exit; input changes during LOW/HIGH SHALL be ignored.
REQ-031 Request-to-ready latency SHALL be 2*(WAIT_CYCLES+1)+1 cycles of ready=0, then 1 cycle of ready=1.

Reset
REQ-032 rst=0 SHALL asynchronously force state=IDLE, counter=0, read_data=0, SRAM_ADDR=0, SRAM_DQ_out=0, SRAM_DQ_oe=0 and SRAM_WE_N=1.
REQ-033 While rst=0, ready SHALL be 1 when no request is present.
REQ-034 Reset asserted mid-access SHALL abort the access without any further SRAM_WE_N pulse.
REQ-035 The block SHALL leave IDLE no earlier than the first rising edge after rst deasserts.

Configuration
REQ-036 Macro LAST_READ_CACHE_EN: when defined, the block SHALL hold a 1-entry buffer (valid, 32-bit word tag, 32-bit data) filled on every completed load.
REQ-037 With LAST_READ_CACHE_EN, a load in IDLE with valid=1 and tag==word SHALL go IDLE->DONE, giving ready=0 for 1 cycle.
REQ-038 On such a hit, read_data SHALL take the buffered data and no SRAM cycle SHALL occur.
REQ-039 With LAST_READ_CACHE_EN, a store whose word matches the tag SHALL update the buffered data with ST_val.
REQ-040 With LAST_READ_CACHE_EN, reset SHALL clear valid.
REQ-041 Macro undefined: no buffer SHALL exist and every load SHALL take the full latency of REQ-031.

Verification
REQ-042 Load: WAIT_CYCLES=1, MEM_R_EN=1, ALU_result=1028, SRAM model returns 0xBEEF at addr 2 and 0xDEAD at addr 3 -> ready=0 for 5 cycles, then ready=1 with read_data=0xDEADBEEF.
REQ-043 Store: ALU_result=1024, ST_val=0x12345678 -> SRAM addr 0 written 0x5678 and addr 1 written 0x1234; exactly one WE_N low cycle per half.
REQ-044 Back-to-back: store then load of the same address -> load returns 0x12345678 with no ready glitch between the two accesses.
REQ-045 Reset mid-access: rst=0 asserted during HIGH of a store -> immediate IDLE, SRAM_WE_N=1, no WE_N pulse after rst rises.
REQ-046 LAST_READ_CACHE_EN defined: two consecutive loads of 1028 -> second load has ready=0 for 1 cycle and no SRAM access.
REQ-047 LAST_READ_CACHE_EN defined: store to 1028 then load of 1028 -> load returns the stored value.
REQ-048 Simultaneous request: MEM_R_EN=MEM_W_EN=1 -> store performed and read_data unchanged.

Source files
------------

// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: 32-bit load/store bridge onto a 16-bit asynchronous SRAM using two half-word accesses.
// Optional feature: define LAST_READ_CACHE_EN for a one-entry buffer that holds the most recent load.
module mem_sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_result,
    input  logic [31:0] ST_val,
    output logic        ready,
    output logic [31:0] read_data,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_out,
    input  logic [15:0] SRAM_DQ_in,
    output logic        SRAM_DQ_oe,
    output logic        SRAM_WE_N
);

`ifdef LAST_READ_CACHE_EN
    localparam int unsigned WORD_W = 32;
`else
    localparam int unsigned WORD_W = 17;
`endif
    localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [31:0]         st_q, st_d;
    logic                wr_q, wr_d;
    logic [31:0]         read_data_q, read_data_d;
    logic [17:0]         sram_addr_q, sram_addr_d;
    logic [15:0]         sram_dq_out_q, sram_dq_out_d;
    logic                sram_dq_oe_q, sram_dq_oe_d;
    logic                sram_we_n_q, sram_we_n_d;
    logic                sram_active;
    logic                half_d;
    logic                req;
    logic [WORD_W-1:0]   in_word;

    assign req     = MEM_R_EN | MEM_W_EN;
    assign in_word = WORD_W'((ALU_result - 32'd1024) >> 2);

`ifdef LAST_READ_CACHE_EN
    logic        cache_valid_q, cache_valid_d;
    logic [31:0] cache_tag_q, cache_tag_d;
    logic [31:0] cache_data_q, cache_data_d;
    logic        load_hit;

    assign load_hit = MEM_R_EN && !MEM_W_EN && cache_valid_q && (cache_tag_q == in_word);
`endif

    // NOTE: every variable gets a default first so no branch can leave a latch behind.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        st_d        = st_q;
        wr_d        = wr_q;
        read_data_d = read_data_q;
`ifdef LAST_READ_CACHE_EN
        cache_valid_d = cache_valid_q;
        cache_tag_d   = cache_tag_q;
        cache_data_d  = cache_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    word_d  = in_word;
                    st_d    = ST_val;
                    wr_d    = MEM_W_EN;
                    cnt_d   = '0;
                    state_d = LOW;
`ifdef LAST_READ_CACHE_EN
                    if (load_hit) begin
                        state_d     = DONE;
                        read_data_d = cache_data_q;
                    end
                    if (MEM_W_EN && cache_valid_q && (cache_tag_q == in_word)) begin
                        cache_data_d = ST_val;
                    end
`endif
                end
            end
            LOW: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    if (!wr_q) read_data_d[15:0] = SRAM_DQ_in;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            HIGH: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (!wr_q) begin
                        read_data_d[31:16] = SRAM_DQ_in;
`ifdef LAST_READ_CACHE_EN
                        cache_valid_d = 1'b1;
                        cache_tag_d   = word_q;
                        cache_data_d  = {SRAM_DQ_in, read_data_q[15:0]};
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // SRAM pins are registered, so they are computed from the state being entered.
        sram_active   = (state_d == LOW) || (state_d == HIGH);
        half_d        = (state_d == HIGH);
        sram_addr_d   = sram_active ? {word_d[16:0], half_d} : sram_addr_q;
        sram_dq_out_d = (sram_active && wr_d) ? (half_d ? st_d[31:16] : st_d[15:0]) : sram_dq_out_q;
        sram_dq_oe_d  = sram_active && wr_d;
        sram_we_n_d   = !(sram_active && wr_d && (cnt_d != LAST_CNT));
    end

    assign ready = ((state_q == IDLE) && !req) || (state_q == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            word_q        <= '0;
            st_q          <= '0;
            wr_q          <= 1'b0;
            read_data_q   <= '0;
            sram_addr_q   <= '0;
            sram_dq_out_q <= '0;
            sram_dq_oe_q  <= 1'b0;
            sram_we_n_q   <= 1'b1;
`ifdef LAST_READ_CACHE_EN
            cache_valid_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            word_q        <= word_d;
            st_q          <= st_d;
            wr_q          <= wr_d;
            read_data_q   <= read_data_d;
            sram_addr_q   <= sram_addr_d;
            sram_dq_out_q <= sram_dq_out_d;
            sram_dq_oe_q  <= sram_dq_oe_d;
            sram_we_n_q   <= sram_we_n_d;
`ifdef LAST_READ_CACHE_EN
            cache_valid_q <= cache_valid_d;
`endif
        end
    end

`ifdef LAST_READ_CACHE_EN
    // NOTE: tag and data stay unreset storage; the reset valid bit alone keeps them from being used.
    always_ff @(posedge clk) begin
        cache_tag_q  <= cache_tag_d;
        cache_data_q <= cache_data_d;
    end
`endif

    assign read_data   = read_data_q;
    assign SRAM_ADDR   = sram_addr_q;
    assign SRAM_DQ_out = sram_dq_out_q;
    assign SRAM_DQ_oe  = sram_dq_oe_q;
    assign SRAM_WE_N   = sram_we_n_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench for mem_sram_ctrl: directed vector table, reset corner cases, then random traffic
// compared against a word-level memory model (plus last-load buffer model when LAST_READ_CACHE_EN is set).
module tb_mem_sram_ctrl;

    localparam int WAIT = 1;
    localparam int FULL_LAT = 2 * (WAIT + 1) + 1;

    logic        clk;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_result;
    logic [31:0] ST_val;
    logic        ready;
    logic [31:0] read_data;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_out;
    logic [15:0] SRAM_DQ_in;
    logic        SRAM_DQ_oe;
    logic        SRAM_WE_N;

    mem_sram_ctrl #(.WAIT_CYCLES(WAIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .MEM_R_EN    (MEM_R_EN),
        .MEM_W_EN    (MEM_W_EN),
        .ALU_result  (ALU_result),
        .ST_val      (ST_val),
        .ready       (ready),
        .read_data   (read_data),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_DQ_out (SRAM_DQ_out),
        .SRAM_DQ_in  (SRAM_DQ_in),
        .SRAM_DQ_oe  (SRAM_DQ_oe),
        .SRAM_WE_N   (SRAM_WE_N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM device: array cleared at start, written while WE_N is low, read asynchronously.
    logic [15:0] sram [0:262143];
    int          we_low_cnt;

    assign SRAM_DQ_in = sram[SRAM_ADDR];

    initial begin
        we_low_cnt = 0;
        for (int i = 0; i < 262144; i++) sram[i] = 16'h0000;
        forever begin
            @(negedge clk);
            if (!SRAM_WE_N) begin
                sram[SRAM_ADDR] = SRAM_DQ_out;
                we_low_cnt = we_low_cnt + 1;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: 32-bit words indexed by the 17-bit SRAM word index.
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] model_rd;
`ifdef LAST_READ_CACHE_EN
    logic        c_valid;
    logic [31:0] c_tag;
`endif

    function automatic logic [31:0] ref_read(input int unsigned key);
        return ref_mem.exists(key) ? ref_mem[key] : 32'h0;
    endfunction

    function automatic logic model_hit(input logic r, input logic w, input logic [31:0] word);
`ifdef LAST_READ_CACHE_EN
        return r && !w && c_valid && (c_tag == word);
`else
        return 1'b0 & r & w & word[0];
`endif
    endfunction

    // Issues one request right after a rising edge; returns ready-low cycles, result and WE_N-low cycles.
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] st,
                          output int lat, output logic [31:0] rd, output int we);
        int we0;
        we0        = we_low_cnt;
        MEM_R_EN   = r;
        MEM_W_EN   = w;
        ALU_result = a;
        ST_val     = st;
        lat        = 0;
        @(negedge clk);
        while (!ready && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        rd = read_data;
        @(posedge clk);
        #1;
        we       = we_low_cnt - we0;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
    endtask

    task automatic run_one(input string name, input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] st, input logic [31:0] exp_rd);
        int          lat;
        int          we;
        logic [31:0] rd;
        logic [31:0] word;
        logic        hit;
        word = (a - 32'd1024) >> 2;
        hit  = model_hit(r, w, word);
        access(r, w, a, st, lat, rd, we);
        check({name, " latency"}, lat, hit ? 1 : FULL_LAT);
        check({name, " read_data"}, rd, exp_rd);
        check({name, " we_low_cycles"}, we, w ? 2 * WAIT : 0);
        if (w) ref_mem[word & 32'h1FFFF] = st;
`ifdef LAST_READ_CACHE_EN
        if (r && !w && !hit) begin
            c_valid = 1'b1;
            c_tag   = word;
        end
`endif
        model_rd = exp_rd;
    endtask

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] addr;
        logic [31:0] st;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int we0;
        vecs[0]  = '{1'b0, 1'b1, 32'd1028,    32'hDEADBEEF, 32'h00000000};
        vecs[1]  = '{1'b0, 1'b1, 32'd1024,    32'h12345678, 32'h00000000};
        vecs[2]  = '{1'b1, 1'b0, 32'd1024,    32'h0,        32'h12345678};
        vecs[3]  = '{1'b1, 1'b0, 32'd1028,    32'h0,        32'hDEADBEEF};
        vecs[4]  = '{1'b1, 1'b1, 32'd1032,    32'hCAFEF00D, 32'hDEADBEEF};
        vecs[5]  = '{1'b1, 1'b0, 32'd1032,    32'h0,        32'hCAFEF00D};
        vecs[6]  = '{1'b0, 1'b1, 32'd1020,    32'hA5A55A5A, 32'hCAFEF00D};
        vecs[7]  = '{1'b1, 1'b0, 32'd1020,    32'h0,        32'hA5A55A5A};
        vecs[8]  = '{1'b1, 1'b0, 32'h00080400, 32'h0,       32'h12345678};
        vecs[9]  = '{1'b1, 1'b0, 32'd1028,    32'h0,        32'hDEADBEEF};
        vecs[10] = '{1'b1, 1'b0, 32'd1028,    32'h0,        32'hDEADBEEF};
        vecs[11] = '{1'b0, 1'b1, 32'd1028,    32'h0BADF00D, 32'hDEADBEEF};
        vecs[12] = '{1'b1, 1'b0, 32'd1028,    32'h0,        32'h0BADF00D};

        model_rd   = 32'h0;
`ifdef LAST_READ_CACHE_EN
        c_valid    = 1'b0;
        c_tag      = 32'h0;
`endif
        rst        = 1'b0;
        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b0;
        ALU_result = 32'h0;
        ST_val     = 32'h0;

        // Reset state, then a request held during reset must not start an access.
        repeat (3) @(negedge clk);
        check("reset ready", 32'(ready), 32'h1);
        check("reset read_data", read_data, 32'h0);
        check("reset addr", 32'(SRAM_ADDR), 32'h0);
        check("reset dq_out", 32'(SRAM_DQ_out), 32'h0);
        check("reset oe", 32'(SRAM_DQ_oe), 32'h0);
        check("reset we_n", 32'(SRAM_WE_N), 32'h1);
        MEM_R_EN   = 1'b1;
        ALU_result = 32'd1028;
        repeat (2) begin
            @(negedge clk);
            check("reset req ready", 32'(ready), 32'h0);
            check("reset req we_n", 32'(SRAM_WE_N), 32'h1);
            check("reset req addr", 32'(SRAM_ADDR), 32'h0);
        end
        MEM_R_EN = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table, issued back to back with no idle cycles in between.
        for (int i = 0; i < 13; i++) begin
            run_one($sformatf("vec%0d", i), vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].st, vecs[i].exp_rd);
        end
        check("sram[0]", 32'(sram[0]), 32'h5678);
        check("sram[1]", 32'(sram[1]), 32'h1234);
        check("sram[2]", 32'(sram[2]), 32'hF00D);
        check("sram[3]", 32'(sram[3]), 32'h0BAD);
        check("sram[3FFFE]", 32'(sram[18'h3FFFE]), 32'h5A5A);
        check("sram[3FFFF]", 32'(sram[18'h3FFFF]), 32'hA5A5);

        // Reset during the HIGH half of a store to word 1000.
        MEM_W_EN   = 1'b1;
        ALU_result = 32'd5024;
        ST_val     = 32'hFFFF0000;
        repeat (4) @(negedge clk);
        check("abort pre addr", 32'(SRAM_ADDR), 32'd2001);
        check("abort pre we_n", 32'(SRAM_WE_N), 32'h0);
        rst      = 1'b0;
        MEM_W_EN = 1'b0;
        #1;
        check("abort we_n", 32'(SRAM_WE_N), 32'h1);
        check("abort oe", 32'(SRAM_DQ_oe), 32'h0);
        check("abort ready", 32'(ready), 32'h1);
        check("abort addr", 32'(SRAM_ADDR), 32'h0);
        check("abort read_data", read_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        we0 = we_low_cnt;
        repeat (6) @(negedge clk);
        check("abort no we pulse", we_low_cnt - we0, 0);
        check("abort idle ready", 32'(ready), 32'h1);
        model_rd = 32'h0;
`ifdef LAST_READ_CACHE_EN
        c_valid  = 1'b0;
`endif
        @(posedge clk);
        #1;

        // Random traffic over a small address window so loads revisit stored words.
        for (int i = 0; i < 300; i++) begin
            logic        r;
            logic        w;
            logic [31:0] a;
            logic [31:0] st;
            logic [31:0] exp_rd;
            int          kind;
            kind = int'($urandom_range(0, 3));
            r    = (kind != 2);
            w    = (kind >= 2);
            a    = 32'd1024 + 32'd4 * $urandom_range(0, 15);
            st   = $urandom;
            exp_rd = (r && !w) ? ref_read(((a - 32'd1024) >> 2) & 32'h1FFFF) : model_rd;
            run_one("rand", r, w, a, st, exp_rd);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                check("rand idle ready", 32'(ready), 32'h1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
